systolic_sequencer: RTL and testbench

Instruction-driven controller that sequences the 2x2 (N x N) systolic array and the unified buffer. It decodes the 16-bit instruction stream (3-bit opcode, 13-bit operand) and latches base addresses. It issues weight-load strobes. On COMPUTE it fetches an activation matrix from the unified buffer, drives it into the array left edge with diagonal skew and zero padding, drains the array, and writes the result matrix back. This replaces hand-skewed a_in driving at top level.

---
 rtl/systolic_sequencer_if.sv | 39 +++
 rtl/systolic_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_sequencer_if.sv
// Bus bundle between the systolic sequencer and its surroundings:
// instruction handshake, weight-load strobe, unified-buffer read/write
// ports, array left-edge feed, result matrix input and status.
// master = sequencer side, slave = environment side.
interface systolic_sequencer_if #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int MEM_AW = 6
);
    logic [15:0]             instruction;
    logic                    instr_valid;
    logic                    instr_ready;
    logic                    weight_load;
    logic [MEM_AW-1:0]       weight_addr;
    logic                    mem_rd_en;
    logic [MEM_AW-1:0]       mem_rd_addr;
    logic [ACC_W-1:0]        mem_rd_data;
    logic [N*DATA_W-1:0]     a_out;
    logic                    a_valid;
    logic [N*N*ACC_W-1:0]    acc_in;
    logic                    mem_wr_en;
    logic [MEM_AW-1:0]       mem_wr_addr;
    logic [ACC_W-1:0]        mem_wr_data;
    logic                    busy;
    logic                    done;

    modport master (
        input  instruction, instr_valid, mem_rd_data, acc_in,
        output instr_ready, weight_load, weight_addr, mem_rd_en, mem_rd_addr,
               a_out, a_valid, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done
    );

    modport slave (
        output instruction, instr_valid, mem_rd_data, acc_in,
        input  instr_ready, weight_load, weight_addr, mem_rd_en, mem_rd_addr,
               a_out, a_valid, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Instruction-driven controller for an N x N systolic array and its unified
// buffer. Decodes 16-bit instructions (3-bit opcode, 13-bit operand), latches
// input/output base addresses, strobes the weight loader, and on COMPUTE runs
// FETCH -> FEED (diagonally skewed) -> DRAIN -> WRITE -> DONE.
// Optional build macro ACC_RELU_EN: clamp negative result words to zero on write.
// Module parameters must match the ones the interface instance was built with.
module systolic_sequencer #(
    parameter int N            = 2,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 32,
    parameter int MEM_AW       = 6,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_sequencer_if.master bus
);
    localparam int NN    = N * N;
    localparam int CNT_W = 8;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [CNT_W-1:0]  FETCH_LAST = CNT_W'(NN);
    localparam logic [CNT_W-1:0]  FEED_LAST  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WRITE_LAST = CNT_W'(NN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [MEM_AW-1:0] ADDR_ONE   = MEM_AW'(1);

    localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_SET_OUT     = 3'b011;
    localparam logic [2:0] OP_COMPUTE     = 3'b100;

    typedef enum logic [2:0] {IDLE, FETCH, FEED, DRAIN, WRITE, DONE} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [MEM_AW-1:0]         in_base;
    logic [MEM_AW-1:0]         out_base;
    logic                      rd_vld_p1;
    logic [IDX_W-1:0]          rd_idx_p1;
    logic signed [DATA_W-1:0]  a_buf    [NN];
    logic signed [ACC_W-1:0]   acc_snap [NN];

    logic [2:0]        opcode;
    logic [MEM_AW-1:0] operand_addr;
    logic              accept;
    logic              unused_bits;

    assign opcode       = bus.instruction[15:13];
    assign operand_addr = bus.instruction[MEM_AW-1:0];
    assign accept       = bus.instr_valid && (state == IDLE);
    assign unused_bits  = ^{bus.instruction[12:MEM_AW], bus.mem_rd_data[ACC_W-1:DATA_W]};

    assign bus.instr_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);

    // Left-edge vector for skew step t: row i sees A[i][t-i], zero outside the diagonal band.
    function automatic logic [N*DATA_W-1:0] feed_vec(input int t);
        logic [N*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if ((t - i >= 0) && (t - i < N)) begin
                v[i*DATA_W +: DATA_W] = a_buf[IDX_W'(i * N + t - i)];
            end
        end
        return v;
    endfunction

    // Result word shaping on the way back to the unified buffer.
    function automatic logic [ACC_W-1:0] wr_word(input logic signed [ACC_W-1:0] w);
`ifdef ACC_RELU_EN
        return (w < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Sequencer FSM: state, counters, base registers and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            in_base         <= '0;
            out_base        <= '0;
            rd_vld_p1       <= 1'b0;
            rd_idx_p1       <= '0;
            bus.weight_load <= 1'b0;
            bus.weight_addr <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.a_out       <= '0;
            bus.a_valid     <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
            bus.done        <= 1'b0;
        end else begin
            bus.weight_load <= 1'b0;
            bus.done        <= 1'b0;
            // read issue -> read return (p1)
            rd_vld_p1       <= bus.mem_rd_en;
            rd_idx_p1       <= IDX_W'(cnt);
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_LOAD_ADDR: in_base <= operand_addr;
                            OP_LOAD_WEIGHT: begin
                                bus.weight_load <= 1'b1;
                                bus.weight_addr <= in_base;
                            end
                            OP_SET_OUT: out_base <= operand_addr;
                            OP_COMPUTE: begin
                                state           <= FETCH;
                                cnt             <= '0;
                                bus.mem_rd_en   <= 1'b1;
                                bus.mem_rd_addr <= in_base;
                            end
                            default: ;
                        endcase
                    end
                end
                FETCH: begin
                    if (cnt == FETCH_LAST) begin
                        state       <= FEED;
                        cnt         <= '0;
                        bus.a_out   <= feed_vec(0);
                        bus.a_valid <= 1'b1;
                    end else begin
                        cnt             <= cnt + CNT_ONE;
                        bus.mem_rd_en   <= (cnt < WRITE_LAST);
                        bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_ONE;
                    end
                end
                FEED: begin
                    if (cnt == FEED_LAST) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        bus.a_out <= '0;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        bus.a_out <= feed_vec(int'(cnt) + 1);
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state           <= WRITE;
                        cnt             <= '0;
                        bus.a_valid     <= 1'b0;
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_wr_addr <= out_base;
                        bus.mem_wr_data <= wr_word(bus.acc_in[0 +: ACC_W]);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WRITE: begin
                    if (cnt == WRITE_LAST) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus.mem_wr_en <= 1'b0;
                        bus.done      <= 1'b1;
                    end else begin
                        cnt             <= cnt + CNT_ONE;
                        bus.mem_wr_addr <= bus.mem_wr_addr + ADDR_ONE;
                        bus.mem_wr_data <= wr_word(acc_snap[IDX_W'(cnt + CNT_ONE)]);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data holding registers (activation tile and result snapshot); no reset needed.
    always_ff @(posedge clk) begin
        if (rd_vld_p1) begin
            a_buf[rd_idx_p1] <= bus.mem_rd_data[DATA_W-1:0];
        end
        if ((state == DRAIN) && (cnt == DRAIN_LAST)) begin
            for (int k = 0; k < NN; k++) begin
                acc_snap[IDX_W'(k)] <= bus.acc_in[k*ACC_W +: ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: scoreboard queues of expected
// reads, left-edge vectors and writes, filled when a COMPUTE is launched and
// drained by a negedge monitor that also models the unified buffer.
module tb_systolic_sequencer;
    localparam int N            = 2;
    localparam int DATA_W       = 16;
    localparam int ACC_W        = 32;
    localparam int MEM_AW       = 6;
    localparam int DRAIN_CYCLES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_sequencer_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .MEM_AW(MEM_AW)) bus ();

    systolic_sequencer #(
        .N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .MEM_AW(MEM_AW), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [ACC_W-1:0]        mem      [64];
    logic [ACC_W-1:0]        acc_vals [N*N];
    logic [MEM_AW-1:0]       exp_rd [$];
    logic [N*DATA_W-1:0]     exp_a  [$];
    logic [MEM_AW+ACC_W-1:0] exp_wr [$];

    // Unified buffer model and output scoreboard, sampled on the falling edge.
    initial begin
        logic [ACC_W-1:0]        rd_pending;
        logic [MEM_AW-1:0]       er;
        logic [N*DATA_W-1:0]     ea;
        logic [MEM_AW+ACC_W-1:0] ew;
        rd_pending = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_data = rd_pending;
            rd_pending = (bus.mem_rd_en === 1'b1) ? mem[bus.mem_rd_addr] : '0;
            if (bus.mem_rd_en === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++;
                    $display("FAIL rd_addr: unexpected read addr=%0d, none expected", bus.mem_rd_addr);
                end else begin
                    er = exp_rd.pop_front();
                    if (bus.mem_rd_addr !== er) begin
                        failures++;
                        $display("FAIL rd_addr: got %0d expected %0d", bus.mem_rd_addr, er);
                    end
                end
            end
            if (bus.a_valid === 1'b1) begin
                checks++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_out: unexpected a_valid with a_out=%h", bus.a_out);
                end else begin
                    ea = exp_a.pop_front();
                    if (bus.a_out !== ea) begin
                        failures++;
                        $display("FAIL a_out: got %h expected %h", bus.a_out, ea);
                    end
                end
            end
            if (bus.mem_wr_en === 1'b1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL mem_wr: unexpected write addr=%0d data=%h", bus.mem_wr_addr, bus.mem_wr_data);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({bus.mem_wr_addr, bus.mem_wr_data} !== ew) begin
                        failures++;
                        $display("FAIL mem_wr: got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.mem_wr_addr, bus.mem_wr_data, ew[ACC_W +: MEM_AW], ew[ACC_W-1:0]);
                    end
                end
                mem[bus.mem_wr_addr] = bus.mem_wr_data;
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic send(input logic [15:0] ins);
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
    endtask

    task automatic load_acc();
        for (int k = 0; k < N*N; k++) bus.acc_in[k*ACC_W +: ACC_W] = acc_vals[k];
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Expected traffic of one COMPUTE; 'full' = false keeps only reads and feed step 0.
    task automatic push_expect(input logic [MEM_AW-1:0] ib, input logic [MEM_AW-1:0] ob, input bit full);
        logic [MEM_AW-1:0]   ad;
        logic [N*DATA_W-1:0] v;
        logic [ACC_W-1:0]    d;
        for (int k = 0; k < N*N; k++) begin
            ad = ib + MEM_AW'(k);
            exp_rd.push_back(ad);
        end
        for (int t = 0; t < 2*N-1; t++) begin
            if (full || t == 0) begin
                v = '0;
                for (int i = 0; i < N; i++) begin
                    if (t - i >= 0 && t - i < N) begin
                        ad = ib + MEM_AW'(i*N + t - i);
                        v[i*DATA_W +: DATA_W] = mem[ad][DATA_W-1:0];
                    end
                end
                exp_a.push_back(v);
            end
        end
        if (full) begin
            for (int k = 0; k < DRAIN_CYCLES; k++) exp_a.push_back('0);
            for (int k = 0; k < N*N; k++) begin
                ad = ob + MEM_AW'(k);
                d  = acc_vals[k];
`ifdef ACC_RELU_EN
                if (d[ACC_W-1]) d = '0;
`endif
                exp_wr.push_back({ad, d});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.instr_ready, bus.busy, bus.done, bus.weight_load, bus.mem_rd_en, bus.mem_wr_en, bus.a_valid} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy,busy,done,wl,rd,wr,av=%b expected 1000000",
                     {bus.instr_ready, bus.busy, bus.done, bus.weight_load, bus.mem_rd_en, bus.mem_wr_en, bus.a_valid});
        end
        checks++;
        if ({bus.a_out, bus.weight_addr, bus.mem_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: a_out=%h weight_addr=%0d wr_data=%h expected all 0", bus.a_out, bus.weight_addr, bus.mem_wr_data);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nop();
        logic [15:0] nops [4];
        nops = '{16'h0000, 16'hA000, 16'hC123, 16'hFFFF};
        for (int k = 0; k < 4; k++) begin
            send(nops[k]);
            checks++;
            if ({bus.instr_ready, bus.busy, bus.weight_load, bus.mem_rd_en} !== 4'b1000) begin
                failures++;
                $display("FAIL nop_%0d: got rdy,busy,wl,rd=%b expected 1000", k,
                         {bus.instr_ready, bus.busy, bus.weight_load, bus.mem_rd_en});
            end
        end
    endtask

    task automatic test_load_weight();
        send(16'h200F);
        send(16'h4000);
        checks++;
        if (bus.weight_load !== 1'b1 || bus.weight_addr !== 6'd15) begin
            failures++;
            $display("FAIL load_weight: got wl=%b addr=%0d expected wl=1 addr=15", bus.weight_load, bus.weight_addr);
        end
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL load_weight_idle: got rdy=%b busy=%b expected 1 0", bus.instr_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.weight_load !== 1'b0) begin
            failures++;
            $display("FAIL load_weight_pulse: got wl=%b expected 0", bus.weight_load);
        end
    endtask

    task automatic test_compute(input string name, input logic [15:0] ld, input logic [15:0] so,
                                input logic [MEM_AW-1:0] ib, input logic [MEM_AW-1:0] ob);
        int cyc;
        int d0;
        send(ld);
        send(so);
        load_acc();
        push_expect(ib, ob, 1'b1);
        d0 = done_cnt;
        send(16'h8000);
        checks++;
        if (bus.busy !== 1'b1 || bus.instr_ready !== 1'b0 || bus.mem_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL %s_start: got busy=%b rdy=%b rd=%b expected 1 0 1", name, bus.busy, bus.instr_ready, bus.mem_rd_en);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc !== 17) begin
            failures++;
            $display("FAIL %s_latency: done at cycle %0d expected 17", name, cyc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.instr_ready !== 1'b1 || done_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL %s_end: got done=%b busy=%b rdy=%b pulses=%0d expected 0 0 1 1",
                     name, bus.done, bus.busy, bus.instr_ready, done_cnt - d0);
        end
        checks++;
        if (exp_rd.size() + exp_a.size() + exp_wr.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d/%0d/%0d pending rd/a/wr expected 0/0/0",
                     name, exp_rd.size(), exp_a.size(), exp_wr.size());
        end
    endtask

    task automatic test_busy_holdoff();
        int cyc;
        send(16'h200F);
        send(16'h6020);
        acc_vals = '{32'd9, 32'd8, 32'd7, 32'd6};
        load_acc();
        push_expect(6'd15, 6'd32, 1'b1);
        send(16'h8000);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.instruction = 16'h2005;
        bus.instr_valid = 1'b1;
        checks++;
        if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b1 || bus.a_valid !== 1'b1) begin
            failures++;
            $display("FAIL holdoff_feed: got rdy=%b busy=%b av=%b expected 0 1 1", bus.instr_ready, bus.busy, bus.a_valid);
        end
        wait_done(6, cyc);
        checks++;
        if (cyc !== 17) begin
            failures++;
            $display("FAIL holdoff_latency: done at cycle %0d expected 17", cyc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL holdoff_ready: got rdy=%b expected 1", bus.instr_ready);
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        send(16'h4000);
        checks++;
        if (bus.weight_load !== 1'b1 || bus.weight_addr !== 6'd5) begin
            failures++;
            $display("FAIL holdoff_accept: got wl=%b addr=%0d expected wl=1 addr=5", bus.weight_load, bus.weight_addr);
        end
        checks++;
        if (exp_rd.size() + exp_a.size() + exp_wr.size() != 0) begin
            failures++;
            $display("FAIL holdoff_drain: %0d entries pending expected 0", exp_rd.size() + exp_a.size() + exp_wr.size());
        end
    endtask

    task automatic test_reset_mid_feed();
        int d0;
        for (int k = 5; k < 9; k++) mem[k] = 32'h0000_0100 + k;
        send(16'h6028);
        push_expect(6'd5, 6'd40, 1'b0);
        d0 = done_cnt;
        send(16'h8000);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.a_valid !== 1'b0 || bus.a_out !== '0) begin
            failures++;
            $display("FAIL midreset_idle: got rdy=%b busy=%b av=%b a_out=%h expected 1 0 0 0",
                     bus.instr_ready, bus.busy, bus.a_valid, bus.a_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (done_cnt !== d0 || exp_rd.size() + exp_a.size() != 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d done pulses, %0d pending expected 0 0",
                     done_cnt - d0, exp_rd.size() + exp_a.size());
        end
        send(16'h4000);
        checks++;
        if (bus.weight_load !== 1'b1 || bus.weight_addr !== 6'd0) begin
            failures++;
            $display("FAIL midreset_base: got wl=%b addr=%0d expected wl=1 addr=0", bus.weight_load, bus.weight_addr);
        end
    endtask

    initial begin
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.acc_in      = '0;
        for (int k = 0; k < 64; k++) mem[k] = '0;

        test_reset();
        test_nop();
        test_load_weight();

        mem[15] = 32'd11; mem[16] = 32'd12; mem[17] = 32'd21; mem[18] = 32'd22;
        acc_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        test_compute("compute", 16'h200F, 16'h6020, 6'd15, 6'd32);

        mem[62] = 32'hDEAD_0005; mem[63] = 32'h0001_0006; mem[0] = 32'd7; mem[1] = 32'hFFFF_8008;
        acc_vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        test_compute("wrap", 16'h3FFE, 16'h7FFF, 6'd62, 6'd63);

        test_busy_holdoff();
        test_reset_mid_feed();

        acc_vals = '{32'hFFFF_FFF6, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
        test_compute("relu", 16'h2000, 16'h6000, 6'd0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
